fifo_pkt_reader: RTL and testbench

Drain side of a switch output-port FIFO. Pops bytes from a `fifo_top` instance, which is in the same `clk` domain, and reframes them into packets. Sends each packet on the output port through a valid/ready handshake, marking start and end of packet. The FIFO holds packets as DA, SA, LEN, then LEN payload bytes. This block is the reader counterpart to the switch's FIFO write path.

---
 rtl/switch_pkg.sv | 34 +++
 rtl/fifo_pkt_reader_if.sv | 44 ++++
 rtl/pkt_out_buf.sv | 68 ++++++
 rtl/fifo_pkt_reader.sv | 155 +++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pkg
//  Description : Shared types and constants for the switch output-port FIFO
//                drain path: header layout, read FSM states and the entry
//                format of the packet output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    // Header is DA, SA, LEN; payload of LEN bytes follows.
    localparam int          HDR_BYTES   = 3;
    localparam logic [1:0]  DA_IDX      = 2'd0;
    localparam logic [1:0]  SA_IDX      = 2'd1;
    localparam logic [1:0]  LEN_IDX     = 2'(HDR_BYTES - 1);

    // Byte width carried by a buffer entry; the reader's W_WIDTH must match.
    localparam int          PKT_W_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR      = 2'd1,
        ST_LEN_WAIT = 2'd2,
        ST_PAYLOAD  = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [PKT_W_WIDTH-1:0] data;
        logic                   sop;
        logic                   eop;
    } buf_entry_t;

endpackage
`default_nettype wire

// File: rtl/fifo_pkt_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkt_reader_if
//  Description : FIFO read-side signals and the packet output port of the
//                reader. The master modport is the reader's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_pkt_reader_if #(
    parameter int W_WIDTH = 8
);
    // FIFO read side
    logic               fifo_empty;
    logic [W_WIDTH-1:0] fifo_data;
    logic               fifo_rd_en;
    // Packet output port
    logic [W_WIDTH-1:0] port_data;
    logic               port_valid;
    logic               port_sop;
    logic               port_eop;
    logic               port_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output port_data,
        output port_valid,
        output port_sop,
        output port_eop,
        input  port_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  port_data,
        input  port_valid,
        input  port_sop,
        input  port_eop,
        output port_ready
    );
endinterface
`default_nettype wire

// File: rtl/pkt_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_out_buf
//  Description : Two-entry FIFO-ordered valid/ready buffer for tagged packet
//                bytes. Entry 0 is always the head. Push and pop may happen
//                in the same cycle without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_out_buf
    import switch_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_push,
    input  wire buf_entry_t i_push_ent,
    input  wire logic       i_ready,
    output logic            o_valid,
    output buf_entry_t      o_head,
    output logic [1:0]      o_occupancy
);

    buf_entry_t r_ent0;
    buf_entry_t r_ent1;
    logic [1:0] r_occ;
    logic       w_pop;

    assign o_valid     = (r_occ != 2'd0);
    assign o_head      = r_ent0;
    assign o_occupancy = r_occ;
    assign w_pop       = o_valid & i_ready;

    // Entry storage and occupancy; the caller never pushes into a full
    // buffer unless it is popping in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_ent0 <= i_push_ent;
                    end else begin
                        r_ent1 <= i_push_ent;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_ent0 <= i_push_ent;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_ent;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkt_reader
//  Description : Drain side of a switch output-port FIFO. Pops DA, SA, LEN
//                and LEN payload bytes, tags SOP/EOP and presents them on a
//                valid/ready port through a two-entry output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_pkt_reader
    import switch_pkg::*;
#(
    parameter int W_WIDTH   = PKT_W_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 port_en,
    fifo_pkt_reader_if.master         bus,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      pkt_cnt
);

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [1:0]         r_hdr_idx;
    logic [W_WIDTH-1:0] r_remaining;
    logic               r_inflight;
    logic               r_if_sop;
    logic               r_if_eop;
    logic               r_if_len;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    logic               w_want;
    logic               w_issue;
    logic               w_room;
    logic [2:0]         w_level;
    logic               w_pop;
    logic               w_len_zero;
    logic               w_valid;
    logic [1:0]         w_occ;
    buf_entry_t         w_push_ent;
    buf_entry_t         w_head;

    // A read may be issued only if its byte is guaranteed a buffer slot:
    // bytes held plus the one in flight, less the one leaving now.
    assign w_pop      = w_valid & bus.port_ready;
    assign w_level    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room     = (w_level < 3'd2);
    assign w_len_zero = (bus.fifo_data == '0);

    // Next-state and read-issue decode.
    always_comb begin
        w_state_nxt = r_state;
        w_want      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE:     w_want = port_en;
            ST_HDR:      w_want = 1'b1;
            ST_PAYLOAD:  w_want = 1'b1;
            default:     w_want = 1'b0;
        endcase
        // Reset wins over everything, including a read request.
        w_issue = w_want & ~bus.fifo_empty & w_room & ~rst;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_issue && (r_hdr_idx == LEN_IDX)) begin
                    w_state_nxt = ST_LEN_WAIT;
                end
            end
            ST_LEN_WAIT: begin
                // LEN arrives this cycle; a zero length ends the packet.
                w_state_nxt = w_len_zero ? ST_IDLE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (w_issue && (r_remaining == W_WIDTH'(1))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Header index, payload countdown, in-flight tag and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_idx   <= DA_IDX;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_if_sop    <= 1'b0;
            r_if_eop    <= 1'b0;
            r_if_len    <= 1'b0;
            r_pkt_cnt   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                // Any read outside PAYLOAD is a header read at r_hdr_idx.
                r_if_sop <= (r_state != ST_PAYLOAD) && (r_hdr_idx == DA_IDX);
                r_if_len <= (r_state != ST_PAYLOAD) && (r_hdr_idx == LEN_IDX);
                r_if_eop <= (r_state == ST_PAYLOAD) && (r_remaining == W_WIDTH'(1));
            end
            if (w_issue && (r_state != ST_PAYLOAD)) begin
                r_hdr_idx <= (r_hdr_idx == LEN_IDX) ? DA_IDX : (r_hdr_idx + 2'd1);
            end
            if (r_state == ST_LEN_WAIT) begin
                r_remaining <= bus.fifo_data;
            end else if (w_issue && (r_state == ST_PAYLOAD)) begin
                r_remaining <= r_remaining - W_WIDTH'(1);
            end
            if (w_pop && w_head.eop) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // A zero-length packet ends on its LEN byte.
    assign w_push_ent.data = bus.fifo_data;
    assign w_push_ent.sop  = r_if_sop;
    assign w_push_ent.eop  = r_if_eop | (r_if_len & w_len_zero);

    pkt_out_buf u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_ent  (w_push_ent),
        .i_ready     (bus.port_ready),
        .o_valid     (w_valid),
        .o_head      (w_head),
        .o_occupancy (w_occ)
    );

    // Port outputs read zero whenever nothing is being offered.
    assign bus.fifo_rd_en = w_issue;
    assign bus.port_valid = w_valid;
    assign bus.port_data  = w_valid ? w_head.data : '0;
    assign bus.port_sop   = w_valid & w_head.sop;
    assign bus.port_eop   = w_valid & w_head.eop;
    assign busy           = (r_state != ST_IDLE) || (w_occ != 2'd0);
    assign pkt_cnt        = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_pkt_reader
//  Description : Directed self-checking bench for fifo_pkt_reader with a
//                behavioural FIFO and a port monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pkt_reader;

    logic        clk;
    logic        rst;
    logic        port_en;
    logic        busy;
    logic [15:0] pkt_cnt;

    fifo_pkt_reader_if #(.W_WIDTH(8)) bus ();

    fifo_pkt_reader #(.W_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .port_en (port_en),
        .bus     (bus),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural FIFO ----------------
    logic [7:0] fq[$];

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fq.size() > 0) begin
            bus.fifo_data  <= fq.pop_front();
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic fifo_byte(input logic [7:0] b);
        fq.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic fifo_pkt(input logic [7:0] da, sa, len, pbase);
        fifo_byte(da);
        fifo_byte(sa);
        fifo_byte(len);
        for (int i = 0; i < len; i++) fifo_byte(pbase + 8'(i));
    endtask

    // Expected words are {sop, eop, data}.
    logic [9:0] exp_q[$];

    task automatic exp_pkt(input logic [7:0] da, sa, len, pbase);
        exp_q.push_back({2'b10, da});
        exp_q.push_back({2'b00, sa});
        exp_q.push_back({1'b0, (len == 8'd0), len});
        for (int i = 0; i < len; i++)
            exp_q.push_back({1'b0, (i == len - 1), pbase + 8'(i)});
    endtask

    // ---------------- ready pattern driver ----------------
    logic       rdy_toggle = 1'b0;
    logic [3:0] rdy_pat    = 4'b1001;   // bit0 first: 1,0,0,1
    int         rdy_ph     = 0;

    always @(negedge clk) begin
        if (rdy_toggle) begin
            bus.port_ready = rdy_pat[rdy_ph];
            rdy_ph = (rdy_ph + 1) % 4;
        end
    end

    // ---------------- monitor: samples 1 time unit before each posedge ----
    int         cyc = 0;
    int         rd_cnt, rd_empty_err, rd_empty_tot = 0, stall_err;
    int         first_rd, first_vld, last_vld, vld_cnt;
    int         arrived = 0, accepted = 0, max_occ;
    logic       prev_rd = 1'b0, prev_stall = 1'b0;
    logic [9:0] prev_word = '0;
    logic [9:0] got_q[$];

    task automatic clear_mon();
        got_q.delete();
        rd_cnt = 0; rd_empty_err = 0; stall_err = 0;
        first_rd = -1; first_vld = -1; last_vld = -1; vld_cnt = 0;
        max_occ = 0;
    endtask

    always @(negedge clk) begin
        logic [9:0] w;
        #4;
        cyc++;
        w = {bus.port_sop, bus.port_eop, bus.port_data};
        if (rst) begin
            prev_rd = 1'b0; prev_stall = 1'b0; arrived = 0; accepted = 0;
        end else begin
            if (prev_stall && (!bus.port_valid || w != prev_word)) stall_err++;
            if (bus.fifo_rd_en) begin
                if (bus.fifo_empty) begin rd_empty_err++; rd_empty_tot++; end
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.port_valid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
            end
            if (prev_rd) arrived++;
            if (bus.port_valid && bus.port_ready) begin
                got_q.push_back(w);
                accepted++;
            end
            if (arrived - accepted > max_occ) max_occ = arrived - accepted;
            prev_rd    = bus.fifo_rd_en;
            prev_stall = bus.port_valid && !bus.port_ready;
            prev_word  = w;
        end
    end

    task automatic wait_pkts(input int n);
        int k = 0;
        while (int'(pkt_cnt) != n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_val("wait_pkt_cnt", 32'(pkt_cnt), 32'(n));
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_out(input string tag);
        int n;
        check_val({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_val($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_rd;
        int eop_seen;
        int k;
        rst = 1'b1; port_en = 1'b1;
        bus.port_ready = 1'b1; bus.fifo_empty = 1'b1; bus.fifo_data = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_val("rst_outs", {26'd0, bus.fifo_rd_en, bus.port_valid, bus.port_sop,
                               bus.port_eop, busy, 1'b0}, 32'd0);
        check_val("rst_data", 32'(bus.port_data), 32'd0);
        check_val("rst_cnt", 32'(pkt_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: LEN=2 packet
        clear_mon();
        fifo_pkt(8'h11, 8'h22, 8'd2, 8'hA0);
        exp_pkt(8'h11, 8'h22, 8'd2, 8'hA0);
        wait_pkts(1);
        compare_out("t1");
        check_val("t1_rd_pulses", 32'(rd_cnt), 32'd5);
        check_val("t1_latency", 32'(first_vld - first_rd), 32'd2);

        // T2: LEN=0 packet
        clear_mon();
        fifo_pkt(8'h33, 8'h44, 8'd0, 8'h00);
        exp_pkt(8'h33, 8'h44, 8'd0, 8'h00);
        wait_pkts(2);
        compare_out("t2");
        check_val("t2_rd_pulses", 32'(rd_cnt), 32'd3);
        check_val("t2_idle", 32'(busy), 32'd0);

        // T3: back-to-back LEN=4 packets
        clear_mon();
        fifo_pkt(8'h51, 8'h52, 8'd4, 8'hB0);
        fifo_pkt(8'h61, 8'h62, 8'd4, 8'hC0);
        exp_pkt(8'h51, 8'h52, 8'd4, 8'hB0);
        exp_pkt(8'h61, 8'h62, 8'd4, 8'hC0);
        wait_pkts(4);
        compare_out("t3");
        check_val("t3_valid_cycles", 32'(vld_cnt), 32'd14);
        check_val("t3_bubbles", 32'(last_vld - first_vld + 1 - vld_cnt), 32'd2);

        // T4: ready toggling on LEN=8, port_en dropped mid-packet
        clear_mon();
        rdy_ph = 0;
        rdy_toggle = 1'b1;
        fifo_pkt(8'h71, 8'h72, 8'd8, 8'hD0);
        exp_pkt(8'h71, 8'h72, 8'd8, 8'hD0);
        repeat (5) @(negedge clk);
        port_en = 1'b0;
        wait_pkts(5);
        rdy_toggle = 1'b0;
        bus.port_ready = 1'b1;
        compare_out("t4");
        check_val("t4_stall_stable", 32'(stall_err), 32'd0);
        check_val("t4_occ_over2", 32'(max_occ > 2), 32'd0);

        // T4b: port_en low in IDLE blocks a new packet
        clear_mon();
        base_rd = rd_cnt;
        fifo_pkt(8'h75, 8'h76, 8'd1, 8'h5A);
        exp_pkt(8'h75, 8'h76, 8'd1, 8'h5A);
        repeat (6) @(negedge clk);
        check_val("t4b_en_gate_rd", 32'(rd_cnt - base_rd), 32'd0);
        port_en = 1'b1;
        wait_pkts(6);
        compare_out("t4b");

        // T5: FIFO runs dry after SA
        clear_mon();
        fifo_byte(8'h81);
        fifo_byte(8'h82);
        exp_pkt(8'h81, 8'h82, 8'd3, 8'hE0);
        repeat (8) @(negedge clk);
        check_val("t5_gap_valid", 32'(bus.port_valid), 32'd0);
        check_val("t5_gap_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        fifo_byte(8'd3);
        fifo_byte(8'hE0); fifo_byte(8'hE1); fifo_byte(8'hE2);
        wait_pkts(7);
        compare_out("t5");
        check_val("t5_rd_while_empty", 32'(rd_empty_err), 32'd0);

        // T6: reset during LEN=6 payload
        clear_mon();
        fifo_pkt(8'h91, 8'h92, 8'd6, 8'hF0);
        k = 0;
        while (got_q.size() < 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("t6_reached_payload", 32'(got_q.size() >= 5), 32'd1);
        rst = 1'b1;
        fq.delete();
        bus.fifo_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t6_outs_clear", {27'd0, bus.fifo_rd_en, bus.port_valid, bus.port_sop,
                                    bus.port_eop, busy}, 32'd0);
        check_val("t6_data_clear", 32'(bus.port_data), 32'd0);
        check_val("t6_cnt_clear", 32'(pkt_cnt), 32'd0);
        repeat (3) @(negedge clk);
        eop_seen = 0;
        foreach (got_q[i]) if (got_q[i][8]) eop_seen++;
        check_val("t6_no_eop", 32'(eop_seen), 32'd0);
        clear_mon();
        fifo_pkt(8'hA5, 8'hA6, 8'd1, 8'h10);
        exp_pkt(8'hA5, 8'hA6, 8'd1, 8'h10);
        wait_pkts(1);
        compare_out("t6_after");

        check_val("all_rd_while_empty", 32'(rd_empty_tot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
